// File: rtl/step_dir_bank.sv
// step_dir_bank: bus-mapped bank of independent step/dir pulse generators with DIR setup,
// timed STEP pulses and sticky completion flags. Defining STEP_DIR_BANK_IRQ_EN adds the completion interrupt.
module step_dir_bank #(
  parameter int CHANNELS     = 12,
  parameter int ADDR_WIDTH   = 8,
  parameter int PERIOD_WIDTH = 24,
  parameter int COUNT_WIDTH  = 32,
  parameter int PULSE_CYCLES = 50,
  parameter int DIR_SETUP    = 25
) (
  input  logic                    clk_in,
  input  logic                    reset_in,
  input  logic                    enable_in,
  input  logic                    write_in,
  input  logic [ADDR_WIDTH-1:0]   addr_in,
  input  logic [31:0]             data_in,
  output logic [31:0]             data_out,
  output logic                    ready_out,
  output logic [CHANNELS-1:0]     step_out,
  output logic [CHANNELS-1:0]     dir_out,
  output logic [CHANNELS-1:0]     drv_en_n_out,
  output logic [CHANNELS-1:0]     busy_out,
  output logic                    done_irq_out,
  output logic [2*CHANNELS-1:0]   fsm_state_dbg
);

  localparam int CH_W = ADDR_WIDTH - 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_HIGH  = 2'd2;
  localparam logic [1:0] ST_LOW   = 2'd3;

  localparam logic [PERIOD_WIDTH-1:0] MIN_PERIOD   = PERIOD_WIDTH'(2 * PULSE_CYCLES);
  localparam logic [PERIOD_WIDTH-1:0] PULSE_LEN    = PERIOD_WIDTH'(PULSE_CYCLES);
  localparam logic [PERIOD_WIDTH-1:0] PULSE_RELOAD = PERIOD_WIDTH'(PULSE_CYCLES - 1);
  localparam logic [PERIOD_WIDTH-1:0] SETUP_RELOAD = PERIOD_WIDTH'(DIR_SETUP - 1);
  localparam logic [PERIOD_WIDTH-1:0] ONE          = PERIOD_WIDTH'(1);

  // Bus handshake: enable_in is the request valid. A request is accepted on an edge where
  // enable_in = 1 and ready_out = 0; ready_out is then high for exactly the following cycle
  // with registered read data, so the master must drop enable_in before issuing another request.
  logic                    ready_q;
  logic [31:0]             data_q;
  logic                    accept;
  logic [CH_W-1:0]         ch_sel;
  logic [1:0]              reg_sel;
  logic [31:0]             rdata;

  logic [CHANNELS-1:0]     wr_ctrl;
  logic [CHANNELS-1:0]     wr_period;
  logic [CHANNELS-1:0]     wr_count;
  logic [CHANNELS-1:0]     wr_status;
  logic [CHANNELS-1:0]     start_req;
  logic [CHANNELS-1:0]     stop_req;

  logic [1:0]              state   [CHANNELS];
  logic [PERIOD_WIDTH-1:0] tmr     [CHANNELS];
  logic [PERIOD_WIDTH-1:0] period  [CHANNELS];
  logic [COUNT_WIDTH-1:0]  count   [CHANNELS];

  logic [CHANNELS-1:0]     ctrl_dir;
  logic [CHANNELS-1:0]     drv_en;
  logic [CHANNELS-1:0]     irq_en;
  logic [CHANNELS-1:0]     dir_q;
  logic [CHANNELS-1:0]     step_q;
  logic [CHANNELS-1:0]     done;
  logic [CHANNELS-1:0]     aborted;
  logic [CHANNELS-1:0]     stop_pend;
  logic [CHANNELS-1:0]     busy;

  logic                    unused_addr;

  assign accept      = enable_in && !ready_q;
  assign ch_sel      = addr_in[ADDR_WIDTH-1:4];
  assign reg_sel     = addr_in[3:2];
  assign unused_addr = ^addr_in[1:0];

  // LOW length is the period clamped to two pulse widths, minus the high time.
  function automatic logic [PERIOD_WIDTH-1:0] low_reload(input logic [PERIOD_WIDTH-1:0] p);
    logic [PERIOD_WIDTH-1:0] eff;
    eff = (p < MIN_PERIOD) ? MIN_PERIOD : p;
    return eff - PULSE_LEN - ONE;
  endfunction

  always_comb begin
    wr_ctrl   = '0;
    wr_period = '0;
    wr_count  = '0;
    wr_status = '0;
    start_req = '0;
    stop_req  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (accept && write_in && (ch_sel == CH_W'(i))) begin
        wr_ctrl[i]   = (reg_sel == 2'd0);
        wr_period[i] = (reg_sel == 2'd1);
        wr_count[i]  = (reg_sel == 2'd2);
        wr_status[i] = (reg_sel == 2'd3);
      end
      // STOP takes priority over START in the same CTRL write.
      stop_req[i]  = wr_ctrl[i] && data_in[2];
      start_req[i] = wr_ctrl[i] && data_in[0] && !data_in[2];
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch_sel == CH_W'(i)) begin
        case (reg_sel)
          2'd0:    rdata = {27'd0, irq_en[i], drv_en[i], 1'b0, ctrl_dir[i], 1'b0};
          2'd1:    rdata = 32'(period[i]);
          2'd2:    rdata = 32'(count[i]);
          default: rdata = {29'd0, aborted[i], done[i], busy[i]};
        endcase
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      ready_q <= 1'b0;
      data_q  <= '0;
    end else begin
      ready_q <= accept;
      data_q  <= (accept && !write_in) ? rdata : '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state[i]  <= ST_IDLE;
        tmr[i]    <= '0;
        period[i] <= '0;
        count[i]  <= '0;
      end
      ctrl_dir  <= '0;
      drv_en    <= '0;
      dir_q     <= '0;
      step_q    <= '0;
      done      <= '0;
      aborted   <= '0;
      stop_pend <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_ctrl[i]) begin
          ctrl_dir[i] <= data_in[1];
          drv_en[i]   <= data_in[3];
        end
        if (wr_period[i]) begin
          period[i] <= data_in[PERIOD_WIDTH-1:0];
        end
        if (wr_count[i] && (state[i] == ST_IDLE)) begin
          count[i] <= data_in[COUNT_WIDTH-1:0];
        end
        if (wr_status[i]) begin
          if (data_in[1]) done[i]    <= 1'b0;
          if (data_in[2]) aborted[i] <= 1'b0;
        end

        // Flag sets below come after the write-1-clear so a coincident set wins.
        case (state[i])
          ST_IDLE: begin
            if (start_req[i]) begin
              if (count[i] == '0) begin
                done[i] <= 1'b1;
              end else begin
                state[i] <= ST_SETUP;
                dir_q[i] <= data_in[1];
                tmr[i]   <= SETUP_RELOAD;
              end
            end
          end
          ST_SETUP: begin
            if (stop_req[i]) begin
              state[i]   <= ST_IDLE;
              aborted[i] <= 1'b1;
            end else if (tmr[i] == '0) begin
              state[i]  <= ST_HIGH;
              step_q[i] <= 1'b1;
              tmr[i]    <= PULSE_RELOAD;
            end else begin
              tmr[i] <= tmr[i] - ONE;
            end
          end
          ST_HIGH: begin
            // A STOP here only takes effect once the pulse has its full width.
            if (tmr[i] == '0) begin
              step_q[i]    <= 1'b0;
              stop_pend[i] <= 1'b0;
              if (stop_pend[i] || stop_req[i]) begin
                state[i]   <= ST_IDLE;
                aborted[i] <= 1'b1;
              end else begin
                state[i] <= ST_LOW;
                tmr[i]   <= low_reload(period[i]);
                if (count[i] != '0) count[i] <= count[i] - 1'b1;
              end
            end else begin
              tmr[i] <= tmr[i] - ONE;
              if (stop_req[i]) stop_pend[i] <= 1'b1;
            end
          end
          default: begin
            if (stop_req[i]) begin
              state[i]   <= ST_IDLE;
              aborted[i] <= 1'b1;
            end else if (tmr[i] == '0) begin
              if (count[i] != '0) begin
                state[i]  <= ST_HIGH;
                step_q[i] <= 1'b1;
                tmr[i]    <= PULSE_RELOAD;
              end else begin
                state[i] <= ST_IDLE;
                done[i]  <= 1'b1;
              end
            end else begin
              tmr[i] <= tmr[i] - ONE;
            end
          end
        endcase
      end
    end
  end

`ifdef STEP_DIR_BANK_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      irq_en <= '0;
      irq_q  <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_ctrl[i]) irq_en[i] <= data_in[4];
      end
      irq_q <= |((done | aborted) & irq_en);
    end
  end

  assign done_irq_out = irq_q;
`else
  assign irq_en       = '0;
  assign done_irq_out = 1'b0;
`endif

  genvar g;
  generate
    for (g = 0; g < CHANNELS; g++) begin : g_ch
      assign busy[g]                = (state[g] != ST_IDLE);
      assign fsm_state_dbg[2*g +: 2] = state[g];
    end
  endgenerate

  assign ready_out    = ready_q;
  assign data_out     = data_q;
  assign step_out     = step_q;
  assign dir_out      = dir_q;
  assign drv_en_n_out = ~drv_en;
  assign busy_out     = busy;

endmodule
